// File: rtl/rsa_ctrl_pkg.sv
// Shared types and defaults for the modular-exponentiation sequencer.
package rsa_ctrl_pkg;

   localparam int unsigned OP_W   = 2;
   localparam int unsigned DATA_W = 13;
   localparam int unsigned MSG_W  = 8;
   localparam int unsigned RES_W  = 16;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned WAIT_W = 8;

   localparam logic [DATA_W-1:0] E_RESET_DEF      = 13'd17;
   localparam logic [DATA_W-1:0] N_RESET_DEF      = 13'd3233;
   localparam int unsigned       INIT_TIMEOUT_DEF = 8;

   typedef enum logic [OP_W-1:0] {
      OP_RSVD    = 2'd0,
      OP_ENCRYPT = 2'd1,
      OP_LOAD_E  = 2'd2,
      OP_LOAD_N  = 2'd3
   } op_e;

   typedef enum logic [3:0] {
      ST_RESYNC_E,
      ST_RESYNC_N,
      ST_IDLE,
      ST_INIT,
      ST_WAIT_INIT,
      ST_MUL,
      ST_MOD,
      ST_DONE,
      ST_CAPTURE,
      ST_LOAD,
      ST_RESP
   } state_e;

   typedef struct packed {
      op_e               op;
      logic [DATA_W-1:0] data;
   } cmd_t;

   typedef struct packed {
      logic initialize;
      logic en_multiply;
      logic en_modulo;
      logic done;
      logic update_e;
      logic update_n;
   } dp_strb_t;

   // A key load is legal when e is non-zero and n is at least 2.
   function automatic logic load_ok(input op_e op, input logic [DATA_W-1:0] v);
      case (op)
         OP_LOAD_E: return (v != '0);
         OP_LOAD_N: return (v >= DATA_W'(2));
         default:   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rsa_controller.sv
// Command sequencer for the modexp datapath: resyncs the key after reset,
// runs init / multiply-modulo loops, validates key loads and returns responses.
module rsa_controller
   import rsa_ctrl_pkg::*;
#(
   parameter logic [DATA_W-1:0] E_RESET      = E_RESET_DEF,
   parameter logic [DATA_W-1:0] N_RESET      = N_RESET_DEF,
   parameter int unsigned       INIT_TIMEOUT = INIT_TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [OP_W-1:0]   cmd_op_i,
   input  logic [DATA_W-1:0] cmd_data_i,
   output logic              res_valid_o,
   input  logic              res_ready_i,
   output logic [RES_W-1:0]  res_data_o,
   output logic              res_err_o,
   output logic              busy_o,
   output logic [DATA_W-1:0] dp_data_o,
   output logic              dp_initialize_o,
   output logic              dp_en_multiply_o,
   output logic              dp_en_modulo_o,
   output logic              dp_done_o,
   output logic              dp_update_e_o,
   output logic              dp_update_n_o,
   input  logic              dp_is_init_done_i,
   input  logic              dp_is_multiplication_done_i,
   input  logic [RES_W-1:0]  dp_output_data_i
);

   state_e             state_q, state_d;
   cmd_t               cmd_q, cmd_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WAIT_W-1:0]  wcnt_q, wcnt_d;
   logic [DATA_W-1:0]  e_sh_q, e_sh_d;
   logic [DATA_W-1:0]  n_sh_q, n_sh_d;
   dp_strb_t           strb_q, strb_d;
   logic [DATA_W-1:0]  dp_data_q, dp_data_d;
   logic [RES_W-1:0]   res_data_q, res_data_d;
   logic               res_err_q, res_err_d;
   logic               res_valid_q, res_valid_d;
   logic               cmd_ready_q, cmd_ready_d;
   logic               busy_q, busy_d;
   op_e                op_in;

   logic unused_mul_done;
   assign unused_mul_done = dp_is_multiplication_done_i;

   assign op_in = op_e'(cmd_op_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RESYNC_E;
         cmd_q       <= '0;
         cnt_q       <= '0;
         wcnt_q      <= '0;
         e_sh_q      <= E_RESET;
         n_sh_q      <= N_RESET;
         strb_q      <= '0;
         dp_data_q   <= '0;
         res_data_q  <= '0;
         res_err_q   <= 1'b0;
         res_valid_q <= 1'b0;
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         cnt_q       <= cnt_d;
         wcnt_q      <= wcnt_d;
         e_sh_q      <= e_sh_d;
         n_sh_q      <= n_sh_d;
         strb_q      <= strb_d;
         dp_data_q   <= dp_data_d;
         res_data_q  <= res_data_d;
         res_err_q   <= res_err_d;
         res_valid_q <= res_valid_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
      end
   end

   // Outputs are computed for the state being entered, so every strobe is a register.
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      cnt_d       = cnt_q;
      wcnt_d      = wcnt_q;
      e_sh_d      = e_sh_q;
      n_sh_d      = n_sh_q;
      res_data_d  = res_data_q;
      res_err_d   = res_err_q;
      strb_d      = '0;
      dp_data_d   = '0;
      res_valid_d = 1'b0;
      cmd_ready_d = 1'b0;

      case (state_q)
         // Reset holds the strobes low, so the first cycle out of reset issues update_e.
         ST_RESYNC_E: begin
            if (!strb_q.update_e) begin
               strb_d.update_e = 1'b1;
               dp_data_d       = E_RESET;
            end else begin
               state_d         = ST_RESYNC_N;
               strb_d.update_n = 1'b1;
               dp_data_d       = N_RESET;
            end
         end
         ST_RESYNC_N: begin
            state_d     = ST_IDLE;
            cmd_ready_d = 1'b1;
         end
         ST_IDLE: begin
            if (cmd_valid_i && cmd_ready_q) begin
               cmd_d.op   = op_in;
               cmd_d.data = cmd_data_i;
               res_data_d = '0;
               res_err_d  = 1'b0;
               case (op_in)
                  OP_ENCRYPT: begin
                     state_d           = ST_INIT;
                     strb_d.initialize = 1'b1;
                     dp_data_d         = DATA_W'(cmd_data_i[MSG_W-1:0]);
                     cnt_d             = CNT_W'(e_sh_q) - CNT_W'(1);
                  end
                  OP_LOAD_E, OP_LOAD_N: begin
                     state_d = ST_LOAD;
                     if (load_ok(op_in, cmd_data_i)) begin
                        dp_data_d = cmd_data_i;
                        if (op_in == OP_LOAD_E) begin
                           strb_d.update_e = 1'b1;
                           e_sh_d          = cmd_data_i;
                        end else begin
                           strb_d.update_n = 1'b1;
                           n_sh_d          = cmd_data_i;
                        end
                     end
                  end
                  default: begin
                     state_d     = ST_RESP;
                     res_valid_d = 1'b1;
                     res_err_d   = 1'b1;
                  end
               endcase
            end else begin
               cmd_ready_d = 1'b1;
            end
         end
         ST_INIT: begin
            state_d = ST_WAIT_INIT;
            wcnt_d  = '0;
         end
         // The flag seen in the first wait cycle predates the initialize strobe.
         ST_WAIT_INIT: begin
            if ((wcnt_q != '0) && dp_is_init_done_i) begin
               if (cnt_q != '0) begin
                  state_d            = ST_MUL;
                  strb_d.en_multiply = 1'b1;
               end else begin
                  state_d          = ST_MOD;
                  strb_d.en_modulo = 1'b1;
               end
            end else if (wcnt_q == WAIT_W'(INIT_TIMEOUT - 1)) begin
               state_d     = ST_RESP;
               res_valid_d = 1'b1;
               res_err_d   = 1'b1;
               res_data_d  = '0;
            end else begin
               wcnt_d = wcnt_q + WAIT_W'(1);
            end
         end
         ST_MUL: begin
            cnt_d            = cnt_q - CNT_W'(1);
            state_d          = ST_MOD;
            strb_d.en_modulo = 1'b1;
         end
         ST_MOD: begin
            if (cnt_q == '0) begin
               state_d     = ST_DONE;
               strb_d.done = 1'b1;
            end else begin
               state_d            = ST_MUL;
               strb_d.en_multiply = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            state_d     = ST_RESP;
            res_valid_d = 1'b1;
            res_data_d  = dp_output_data_i;
            res_err_d   = 1'b0;
         end
         ST_LOAD: begin
            state_d     = ST_RESP;
            res_valid_d = 1'b1;
            res_data_d  = '0;
            res_err_d   = !load_ok(cmd_q.op, cmd_q.data);
         end
         ST_RESP: begin
            if (res_ready_i) begin
               state_d     = ST_IDLE;
               cmd_ready_d = 1'b1;
            end else begin
               res_valid_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_RESYNC_E;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   assign cmd_ready_o      = cmd_ready_q;
   assign res_valid_o      = res_valid_q;
   assign res_data_o       = res_data_q;
   assign res_err_o        = res_err_q;
   assign busy_o           = busy_q;
   assign dp_data_o        = dp_data_q;
   assign dp_initialize_o  = strb_q.initialize;
   assign dp_en_multiply_o = strb_q.en_multiply;
   assign dp_en_modulo_o   = strb_q.en_modulo;
   assign dp_done_o        = strb_q.done;
   assign dp_update_e_o    = strb_q.update_e;
   assign dp_update_n_o    = strb_q.update_n;

endmodule

// File: tb/tb_rsa_controller.sv
// Self-checking bench for rsa_controller with a behavioural datapath and a
// plain-arithmetic modexp reference.
module tb_rsa_controller;

   localparam logic [1:0] C_RSVD = 2'd0;
   localparam logic [1:0] C_ENC  = 2'd1;
   localparam logic [1:0] C_LDE  = 2'd2;
   localparam logic [1:0] C_LDN  = 2'd3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'd0;
   logic [12:0] cmd_data = 13'd0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [15:0] res_data;
   logic        res_err;
   logic        busy;
   logic [12:0] dp_data;
   logic        dp_initialize, dp_en_multiply, dp_en_modulo, dp_done, dp_update_e, dp_update_n;
   logic        dp_is_init_done;
   logic        dp_is_multiplication_done;
   logic [15:0] dp_output_data;

   int n_cmp = 0;
   int n_err = 0;

   // Reference key state, updated only by loads the rules accept.
   int exp_e = 17;
   int exp_n = 3233;

   always #5 clk = ~clk;

   rsa_controller dut (
      .clk                         (clk),
      .rst_n                       (rst_n),
      .cmd_valid_i                 (cmd_valid),
      .cmd_ready_o                 (cmd_ready),
      .cmd_op_i                    (cmd_op),
      .cmd_data_i                  (cmd_data),
      .res_valid_o                 (res_valid),
      .res_ready_i                 (res_ready),
      .res_data_o                  (res_data),
      .res_err_o                   (res_err),
      .busy_o                      (busy),
      .dp_data_o                   (dp_data),
      .dp_initialize_o             (dp_initialize),
      .dp_en_multiply_o            (dp_en_multiply),
      .dp_en_modulo_o              (dp_en_modulo),
      .dp_done_o                   (dp_done),
      .dp_update_e_o               (dp_update_e),
      .dp_update_n_o               (dp_update_n),
      .dp_is_init_done_i           (dp_is_init_done),
      .dp_is_multiplication_done_i (dp_is_multiplication_done),
      .dp_output_data_i            (dp_output_data)
   );

   // Behavioural datapath: accumulator, base, key registers and init flag.
   logic [31:0] acc = 32'd0;
   logic [31:0] base = 32'd0;
   logic [12:0] m_n = 13'd1;
   logic [12:0] m_e = 13'd1;
   logic        done_int = 1'b0;
   logic        init_flag = 1'b0;
   logic        mul_flag = 1'b0;
   logic        suppress_init = 1'b0;

   always @(posedge clk) begin
      if (dp_initialize) begin
         acc      <= {24'd0, dp_data[7:0]};
         base     <= {24'd0, dp_data[7:0]};
         done_int <= !suppress_init;
      end
      if (dp_en_multiply) acc <= acc * base;
      if (dp_en_modulo)   acc <= acc % {19'd0, m_n};
      if (dp_done)        done_int <= 1'b0;
      if (dp_update_e)    m_e <= dp_data;
      if (dp_update_n)    m_n <= dp_data;
      init_flag <= done_int;
      mul_flag  <= dp_en_multiply;
   end
   assign dp_is_init_done           = init_flag;
   assign dp_is_multiplication_done = mul_flag;
   assign dp_output_data            = acc[15:0];

   // Strobe monitor: exclusivity, idle data bus, MUL/MOD alternation, pulse counts.
   int   cnt_mul = 0, cnt_mod = 0, cnt_upe = 0, cnt_upn = 0;
   logic prev_mul = 1'b0;
   always @(negedge clk) begin
      int s;
      if (rst_n) begin
         s = int'(dp_initialize) + int'(dp_en_multiply) + int'(dp_en_modulo)
           + int'(dp_done) + int'(dp_update_e) + int'(dp_update_n);
         n_cmp++;
         if (s > 1) begin
            n_err++;
            $display("FAIL strobe_onehot: %0d strobes high, required at most 1", s);
         end
         if (!dp_initialize && !dp_update_e && !dp_update_n) begin
            n_cmp++;
            if (dp_data !== 13'd0) begin
               n_err++;
               $display("FAIL dp_data_idle: got %0d, required 0", dp_data);
            end
         end
         if (dp_en_multiply) begin
            n_cmp++;
            if (prev_mul) begin
               n_err++;
               $display("FAIL mul_mod_alternate: two MUL pulses without a MOD between");
            end
            prev_mul = 1'b1;
            cnt_mul++;
         end
         if (dp_en_modulo) begin
            prev_mul = 1'b0;
            cnt_mod++;
         end
         if (dp_update_e) cnt_upe++;
         if (dp_update_n) cnt_upn++;
      end
   end

   function automatic int modexp(input int m, input int e, input int n);
      longint r = 1;
      for (int i = 0; i < e; i++) r = (r * longint'(m)) % longint'(n);
      return int'(r);
   endfunction

   // Issue one command, wait for its response, optionally stall res_ready.
   task automatic run_cmd(input logic [1:0] op, input logic [12:0] data, input int hold,
                          output logic [15:0] rdata, output logic rerr, output int lat);
      int c;
      bit got;
      lat = -1; rdata = 16'd0; rerr = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
      c = 0;
      while (!cmd_ready && c < 200) begin @(negedge clk); c++; end
      if (!cmd_ready) begin
         n_cmp++; n_err++;
         $display("FAIL accept_timeout: cmd_ready never high for op %0d", op);
         cmd_valid = 1'b0;
         return;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      c = 1; got = 1'b0;
      while (c < 300 && !got) begin
         if (res_valid) got = 1'b1;
         else begin @(negedge clk); c++; end
      end
      if (!got) begin
         n_cmp++; n_err++;
         $display("FAIL resp_timeout: no res_valid for op %0d", op);
         return;
      end
      lat = c; rdata = res_data; rerr = res_err;
      for (int i = 0; i < hold; i++) begin
         cmd_valid = 1'b1; cmd_op = C_LDE; cmd_data = 13'd0;
         @(negedge clk);
         n_cmp++;
         if (res_valid !== 1'b1 || res_data !== rdata || res_err !== rerr || cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL hold_stable: valid=%b data=%0d err=%b ready=%b, required 1/%0d/%b/0",
                     res_valid, res_data, res_err, cmd_ready, rdata, rerr);
         end
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      n_cmp++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL post_handshake: res_valid=%b cmd_ready=%b, required 0/1", res_valid, cmd_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({cmd_ready, res_valid, res_err, busy, dp_initialize, dp_en_multiply, dp_en_modulo,
           dp_done, dp_update_e, dp_update_n} !== 10'd0 || dp_data !== 13'd0 || res_data !== 16'd0) begin
         n_err++;
         $display("FAIL reset_outputs: some output nonzero during reset, required all 0");
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (dp_update_e !== 1'b1 || dp_data !== 13'd17) begin
         n_err++;
         $display("FAIL resync_e: update_e=%b data=%0d, required 1/17", dp_update_e, dp_data);
      end
      @(negedge clk);
      n_cmp++;
      if (dp_update_n !== 1'b1 || dp_data !== 13'd3233) begin
         n_err++;
         $display("FAIL resync_n: update_n=%b data=%0d, required 1/3233", dp_update_n, dp_data);
      end
      @(negedge clk);
      n_cmp++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL first_idle: cmd_ready=%b busy=%b, required 1/0", cmd_ready, busy);
      end
      exp_e = 17; exp_n = 3233;
   endtask

   task automatic test_encrypt_default();
      logic [15:0] d; logic er; int lat; int m0, d0;
      m0 = cnt_mul; d0 = cnt_mod;
      run_cmd(C_ENC, 13'd65, 0, d, er, lat);
      n_cmp++;
      if (d !== 16'd2790 || er !== 1'b0 || lat != 38) begin
         n_err++;
         $display("FAIL encrypt_65: data=%0d err=%b lat=%0d, required 2790/0/38", d, er, lat);
      end
      n_cmp++;
      if (cnt_mul - m0 != 16 || cnt_mod - d0 != 16) begin
         n_err++;
         $display("FAIL encrypt_65_pulses: mul=%0d mod=%0d, required 16/16", cnt_mul - m0, cnt_mod - d0);
      end
   endtask

   task automatic test_loads_and_encrypt();
      logic [15:0] d; logic er; int lat; int m0, d0, u0;
      u0 = cnt_upe;
      run_cmd(C_LDE, 13'd10, 0, d, er, lat);
      n_cmp++;
      if (er !== 1'b0 || d !== 16'd0 || lat != 2 || cnt_upe - u0 != 1 || m_e !== 13'd10) begin
         n_err++;
         $display("FAIL load_e_10: err=%b data=%0d lat=%0d pulses=%0d dp_e=%0d, required 0/0/2/1/10",
                  er, d, lat, cnt_upe - u0, m_e);
      end
      exp_e = 10;
      run_cmd(C_LDN, 13'd1000, 0, d, er, lat);
      n_cmp++;
      if (er !== 1'b0 || lat != 2 || m_n !== 13'd1000) begin
         n_err++;
         $display("FAIL load_n_1000: err=%b lat=%0d dp_n=%0d, required 0/2/1000", er, lat, m_n);
      end
      exp_n = 1000;
      m0 = cnt_mul; d0 = cnt_mod;
      run_cmd(C_ENC, 13'd2, 0, d, er, lat);
      n_cmp++;
      if (d !== 16'd24 || er !== 1'b0 || lat != 24 || cnt_mul - m0 != 9 || cnt_mod - d0 != 9) begin
         n_err++;
         $display("FAIL encrypt_2: data=%0d err=%b lat=%0d mul=%0d mod=%0d, required 24/0/24/9/9",
                  d, er, lat, cnt_mul - m0, cnt_mod - d0);
      end
   endtask

   task automatic test_e_one();
      logic [15:0] d; logic er; int lat; int m0, d0;
      run_cmd(C_LDE, 13'd1, 0, d, er, lat);
      run_cmd(C_LDN, 13'd3233, 0, d, er, lat);
      exp_e = 1; exp_n = 3233;
      m0 = cnt_mul; d0 = cnt_mod;
      run_cmd(C_ENC, 13'd200, 0, d, er, lat);
      n_cmp++;
      if (d !== 16'd200 || er !== 1'b0 || lat != 7 || cnt_mul - m0 != 0 || cnt_mod - d0 != 1) begin
         n_err++;
         $display("FAIL encrypt_e1: data=%0d err=%b lat=%0d mul=%0d mod=%0d, required 200/0/7/0/1",
                  d, er, lat, cnt_mul - m0, cnt_mod - d0);
      end
   endtask

   task automatic test_errors();
      logic [15:0] d; logic er; int lat; int ue, un;
      logic [1:0]  ops  [3] = '{C_LDN, C_LDE, C_RSVD};
      logic [12:0] vals [3] = '{13'd1, 13'd0, 13'd55};
      for (int i = 0; i < 3; i++) begin
         ue = cnt_upe; un = cnt_upn;
         run_cmd(ops[i], vals[i], 0, d, er, lat);
         n_cmp++;
         if (er !== 1'b1 || d !== 16'd0 || cnt_upe != ue || cnt_upn != un) begin
            n_err++;
            $display("FAIL error_cmd_%0d: err=%b data=%0d upd_e=%0d upd_n=%0d, required 1/0/0/0",
                     i, er, d, cnt_upe - ue, cnt_upn - un);
         end
      end
      // Keys must still be e=1, n=3233: encrypt a random byte and expect it mod n.
      begin
         int m;
         m = $urandom_range(0, 255);
         run_cmd(C_ENC, 13'(m), 0, d, er, lat);
         n_cmp++;
         if (d !== 16'(modexp(m, exp_e, exp_n)) || er !== 1'b0) begin
            n_err++;
            $display("FAIL shadow_unchanged: data=%0d err=%b, required %0d/0", d, er, modexp(m, exp_e, exp_n));
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] d; logic er; int lat; int e, n, m, lexp;
      for (int k = 0; k < 6; k++) begin
         e = $urandom_range(1, 14);
         n = $urandom_range(2, 8191);
         m = $urandom_range(0, 255);
         run_cmd(C_LDE, 13'(e), 0, d, er, lat);
         run_cmd(C_LDN, 13'(n), 0, d, er, lat);
         exp_e = e; exp_n = n;
         run_cmd(C_ENC, 13'(m), 0, d, er, lat);
         lexp = (e == 1) ? 7 : 2 * e + 4;
         n_cmp++;
         if (d !== 16'(modexp(m, exp_e, exp_n)) || er !== 1'b0 || lat != lexp) begin
            n_err++;
            $display("FAIL random_%0d: m=%0d e=%0d n=%0d data=%0d err=%b lat=%0d, required %0d/0/%0d",
                     k, m, e, n, d, er, lat, modexp(m, exp_e, exp_n), lexp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] d; logic er; int lat; int m;
      m = $urandom_range(0, 255);
      run_cmd(C_ENC, 13'(m), 5, d, er, lat);
      n_cmp++;
      if (d !== 16'(modexp(m, exp_e, exp_n)) || er !== 1'b0) begin
         n_err++;
         $display("FAIL backpressure_data: data=%0d err=%b, required %0d/0", d, er, modexp(m, exp_e, exp_n));
      end
      run_cmd(C_LDE, 13'd17, 0, d, er, lat);
      n_cmp++;
      if (er !== 1'b0 || lat != 2 || m_e !== 13'd17) begin
         n_err++;
         $display("FAIL next_after_handshake: err=%b lat=%0d dp_e=%0d, required 0/2/17", er, lat, m_e);
      end
      exp_e = 17;
   endtask

   task automatic test_init_timeout();
      logic [15:0] d; logic er; int lat;
      suppress_init = 1'b1;
      run_cmd(C_ENC, 13'd9, 0, d, er, lat);
      suppress_init = 1'b0;
      n_cmp++;
      if (er !== 1'b1 || d !== 16'd0 || lat != 10) begin
         n_err++;
         $display("FAIL init_timeout: err=%b data=%0d lat=%0d, required 1/0/10", er, d, lat);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [15:0] d; logic er; int lat; int c;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = C_ENC; cmd_data = 13'd77;
      c = 0;
      while (!cmd_ready && c < 100) begin @(negedge clk); c++; end
      @(negedge clk);
      cmd_valid = 1'b0;
      c = 0;
      while (!dp_en_multiply && c < 50) begin @(negedge clk); c++; end
      n_cmp++;
      if (!dp_en_multiply) begin
         n_err++;
         $display("FAIL mid_op_reach_mul: never saw MUL within 50 cycles");
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({cmd_ready, res_valid, busy, dp_initialize, dp_en_multiply, dp_en_modulo,
           dp_done, dp_update_e, dp_update_n} !== 9'd0 || dp_data !== 13'd0) begin
         n_err++;
         $display("FAIL mid_op_reset_outputs: outputs nonzero under reset, required 0");
      end
      prev_mul = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (dp_update_e !== 1'b1 || dp_data !== 13'd17) begin
         n_err++;
         $display("FAIL mid_op_resync_e: update_e=%b data=%0d, required 1/17", dp_update_e, dp_data);
      end
      @(negedge clk);
      n_cmp++;
      if (dp_update_n !== 1'b1 || dp_data !== 13'd3233) begin
         n_err++;
         $display("FAIL mid_op_resync_n: update_n=%b data=%0d, required 1/3233", dp_update_n, dp_data);
      end
      exp_e = 17; exp_n = 3233;
      run_cmd(C_ENC, 13'd65, 0, d, er, lat);
      n_cmp++;
      if (d !== 16'd2790 || er !== 1'b0 || lat != 38) begin
         n_err++;
         $display("FAIL mid_op_encrypt_65: data=%0d err=%b lat=%0d, required 2790/0/38", d, er, lat);
      end
   endtask

   initial begin
      test_reset();
      test_encrypt_default();
      test_loads_and_encrypt();
      test_e_one();
      test_errors();
      test_random();
      test_back_to_back();
      test_init_timeout();
      test_reset_mid_op();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rsa_controller.md
# rsa_controller

Sequencer for the 8-bit-message modular-exponentiation datapath. Accepts commands (encrypt a byte, load exponent, load modulus) over a valid/ready port and drives the datapath strobes: initialize, alternating multiply/modulo, done, update_e and update_n. Returns one response per command over a second valid/ready port. Keeps shadow copies of e and n, validates loads, and re-synchronises the datapath key after reset.

## Interface
- E_RESET, 17: exponent after reset (shadow and datapath)
- N_RESET, 3233: modulus after reset
- INIT_TIMEOUT, 8: maximum WAIT_INIT cycles before an error response
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_op  in  2  0 reserved, 1 ENCRYPT, 2 LOAD_E, 3 LOAD_N
- cmd_data  in  13  message in [7:0] for ENCRYPT; key value for loads
- res_valid / res_ready  out / in  1  response handshake
- res_data  out  16  ciphertext; 0 for loads and errors
- res_err  out  1  response is an error
- busy  out  1  state is not IDLE
- dp_data  out  13  datapath data bus
- dp_initialize, dp_en_multiply, dp_en_modulo, dp_done, dp_update_e, dp_update_n  out  1 each  datapath strobes; at most one high per cycle
- dp_is_init_done  in  1  datapath flag; registered, lags by one cycle
- dp_is_multiplication_done  in  1  monitored only
- dp_output_data  in  16  datapath result

## Operation
- States: RESYNC_E, RESYNC_N, IDLE, INIT, WAIT_INIT, MUL, MOD, DONE, CAPTURE, LOAD, RESP.
- Reset value of every output is 0. The state resets to RESYNC_E. Shadow registers reset to E_RESET and N_RESET.
- Resync sequence:
  - RESYNC_E: drive dp_update_e with dp_data = E_RESET.
  - RESYNC_N: drive dp_update_n with dp_data = N_RESET.
  - Then go to IDLE. A reset in the middle of an operation therefore always restores a consistent key.
- IDLE: cmd_ready = 1. On acceptance, register op and data, then:
  - ENCRYPT goes to INIT.
  - LOAD_E/LOAD_N go to LOAD.
  - Op 0 goes to RESP with res_err = 1.
- INIT: dp_initialize = 1 and dp_data = {5'b0, msg}. Load iteration counter cnt = e_shadow − 1 (16 bit).
- WAIT_INIT: lasts at least 2 cycles. The flag is ignored in the first cycle because it is stale.
  - From the second cycle, dp_is_init_done = 1 exits to MUL if cnt ≠ 0, or to MOD if cnt = 0.
  - After INIT_TIMEOUT cycles with no flag, go to RESP with res_err = 1.
- MUL: dp_en_multiply = 1, cnt decrements, then go to MOD.
- MOD: dp_en_modulo = 1. Go to DONE if cnt = 0, else to MUL.
- DONE: dp_done = 1.
- CAPTURE: res_data <= dp_output_data.
- RESP: res_valid = 1. Hold res_data and res_err until res_ready, then go to IDLE.
- LOAD checks the value, then goes to RESP:
  - LOAD_E with value 0 is an error.
  - LOAD_N with value < 2 is an error.
  - Otherwise pulse dp_update_e or dp_update_n with dp_data = cmd_data and update the shadow register.
  - An error performs no update.
- dp_data is 0 whenever no data strobe is high.
- Arithmetic: reduced value < 8192 times byte < 2^21, which fits the 32-bit datapath accumulator. No overflow handling is needed.

## Timing
- Count the accept edge as A, and the cycle after A as cycle 1.
- ENCRYPT, e ≥ 2:
  - INIT: cycle 1.
  - WAIT_INIT: cycles 2–3.
  - MUL/MOD pairs: cycles 4 to 2e+1.
  - DONE: cycle 2e+2.
  - CAPTURE: cycle 2e+3.
  - res_valid first high in cycle 2e+4 (cycle 38 for e = 17).
- ENCRYPT, e = 1: one MOD only, res_valid in cycle 7.
- Loads: LOAD in cycle 1, RESP in cycle 2.
- cmd_ready is high only in IDLE. Commands are strictly serialised, and res_valid is never dropped before res_ready.
- First IDLE (cmd_ready = 1) is the 3rd cycle after rst_n deasserts.

## Structure
- Package rsa_ctrl_pkg holds:
  - the op codes
  - the state enum
  - E_RESET, N_RESET and INIT_TIMEOUT defaults
- Single module. The state machine, counter and shadow registers are tightly coupled, so no sub-module is needed.

## Test plan
- After reset: update_e pulses with 17, then update_n with 3233. ENCRYPT 65 → res_data 2790, res_err 0, res_valid in cycle 38.
- LOAD_E 10 and LOAD_N 1000, then ENCRYPT 2 → res_data 24. Exactly 9 MUL pulses interleaved with 9 MOD pulses.
- LOAD_E 1, then ENCRYPT 200 (n = 3233) → res_data 200, zero MUL pulses, one MOD.
- LOAD_N 1, LOAD_E 0, and op 0 → each gives res_err 1, no update strobes, and unchanged shadow keys.
- res_ready held low for 5 cycles → res_valid and res_data stable, cmd_ready low. The next command is accepted only after the handshake.
- rst_n asserted during MUL → outputs 0 immediately, resync to 17/3233. A following ENCRYPT 65 → 2790.
